axi_lite_ram: RTL and testbench

//  AXI4-lite responder (slave) backed by a word-addressed RAM; the memory-side end of the core's
//  AXI4-lite initiator port, serving instruction fetches, data loads and byte/half/word stores.

---
 rtl/axi_lite_ram.sv | 159 +++++++++++++++
 tb/tb_axi_lite_ram.sv | 139 +++++++++++++
 2 files changed

// File: rtl/axi_lite_ram.sv
// axi_lite_ram: AXI4-lite responder backed by a word-addressed RAM.
// Independent read and write FSMs, each holding one outstanding transaction.
module axi_lite_ram #(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  localparam logic [32:0] SPAN = 33'(4) << DEPTH_LOG2;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
  function automatic logic [1:0] resp_of(input logic [32:0] off, input logic bad);
    return off >= SPAN ? 2'b11 : bad ? 2'b10 : 2'b00;
  endfunction
  logic [31:0] mem_q [2**DEPTH_LOG2];
  wstate_e wstate_q, wstate_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, awinst_q, awinst_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d;
  rstate_e rstate_q, rstate_d;
  logic [31:0] araddr_q, araddr_d, rdata_q, rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] rresp_q, rresp_d;
  logic aw_hs, w_hs, commit, do_write;
  logic [31:0] cur_addr, cur_data;
  logic [3:0] cur_strb;
  logic [32:0] wr_off, rd_off;
  logic [1:0] wr_resp, rd_resp;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic unused_prot;
  assign unused_prot = ^{arprot, awprot[1:0]};
  assign awready = wstate_q == W_IDLE && !aw_held_q;
  assign wready  = wstate_q == W_IDLE && !w_held_q;
  assign bvalid  = wstate_q == W_RESP;
  assign bresp   = bresp_q;
  assign arready = rstate_q == R_IDLE;
  assign rvalid  = rstate_q == R_RESP;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  // Address and data may be held from earlier cycles or arriving right now
  assign cur_addr = aw_held_q ? awaddr_q : awaddress;
  assign cur_data = w_held_q ? wdata_q : wdata;
  assign cur_strb = w_held_q ? wstrb_q : wstrb;
  assign commit   = wstate_q == W_IDLE && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_off   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign wr_resp  = resp_of(wr_off, wr_off[1:0] != 2'b00 || (aw_held_q ? awinst_q : awprot[2]));
  assign wr_idx   = wr_off[DEPTH_LOG2+1:2];
  assign do_write = commit && wr_resp == 2'b00;
  assign rd_off   = {1'b0, araddr_q} - {1'b0, BASE_ADDR};
  assign rd_resp  = resp_of(rd_off, rd_off[1:0] != 2'b00);
  assign rd_idx   = rd_off[DEPTH_LOG2+1:2];
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    awinst_d  = awinst_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    if (commit) begin
      wstate_d  = W_RESP;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bresp_d   = wr_resp;
    end else if (wstate_q == W_IDLE) begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        awaddr_d  = awaddress;
        awinst_d  = awprot[2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = wdata;
        wstrb_d  = wstrb;
      end
    end else if (bready) begin
      wstate_d = W_IDLE;
    end
  end
  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rstate_q == R_IDLE && arvalid) begin
      rstate_d = R_WAIT;
      araddr_d = araddress;
      cnt_d    = 4'(READ_LATENCY - 1);
    end else if (rstate_q == R_WAIT && cnt_q == 4'd0) begin
      rstate_d = R_RESP;
      rresp_d  = rd_resp;
      rdata_d  = rd_resp == 2'b00 ? mem_q[rd_idx] : 32'h0;
    end else if (rstate_q == R_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end else if (rstate_q == R_RESP && rready) begin
      rstate_d = R_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rstate_q  <= R_IDLE;
      cnt_q     <= 4'd0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end
  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    awinst_q <= awinst_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    araddr_q <= araddr_d;
  end
  // RAM is never reset; a commit is suppressed while reset is low
  always_ff @(posedge clk) begin
    if (do_write && reset)
      for (int i = 0; i < 4; i++)
        if (cur_strb[i]) mem_q[wr_idx][8*i +: 8] <= cur_data[8*i +: 8];
  end
endmodule

// File: tb/tb_axi_lite_ram.sv
// tb_axi_lite_ram: directed checks of the AXI4-lite RAM responder.
module tb_axi_lite_ram;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] awaddress, wdata, araddress, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  int checks = 0;
  int passed = 0;
  axi_lite_ram #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] p, input int lead, input int hold, input logic [1:0] exp_resp);
    @(negedge clk);
    wvalid = 1'b1; wdata = d; wstrb = s;
    if (lead == 0) begin awvalid = 1'b1; awaddress = a; awprot = p; end
    @(negedge clk);
    wvalid = 1'b0;
    if (lead > 0) begin
      chk({tag, " wready after W"}, wready, 0);
      repeat (lead - 1) @(negedge clk);
      chk({tag, " bvalid before AW"}, bvalid, 0);
      awvalid = 1'b1; awaddress = a; awprot = p;
      @(negedge clk);
    end
    awvalid = 1'b0;
    chk({tag, " bvalid"}, bvalid, 1);
    chk({tag, " bresp"}, bresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " bvalid held"}, bvalid, 1);
      chk({tag, " bresp held"}, bresp, exp_resp);
      chk({tag, " awready held"}, awready, 0);
      chk({tag, " wready held"}, wready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, " bvalid done"}, bvalid, 0);
    chk({tag, " ready again"}, {awready, wready}, 2'b11);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    @(negedge clk);
    arvalid = 1'b1; araddress = a;
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, " arready busy"}, arready, 0);
    repeat (LAT - 1) begin
      chk({tag, " rvalid early"}, rvalid, 0);
      @(negedge clk);
    end
    chk({tag, " rvalid early"}, rvalid, 0);
    @(negedge clk);
    chk({tag, " rvalid"}, rvalid, 1);
    chk({tag, " rdata"}, rdata, exp_d);
    chk({tag, " rresp"}, rresp, exp_r);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, " rvalid done"}, rvalid, 0);
    chk({tag, " arready again"}, arready, 1);
  endtask
  initial begin
    reset = 1'b0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    awaddress = '0; wdata = '0; araddress = '0; awprot = '0; arprot = '0; wstrb = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset readies", {awready, wready, arready}, 3'b111);
    chk("reset valids", {bvalid, rvalid}, 2'b00);
    chk("reset resps", {bresp, rresp}, 4'b0000);
    chk("reset rdata", rdata, 32'h0);
    wr("wr10", 32'h10, 32'hDEADBEEF, 4'b1111, 3'b000, 0, 0, 2'b00);
    rd("rd10", 32'h10, 32'hDEADBEEF, 2'b00);
    wr("wlead", 32'h10, 32'h0000AB00, 4'b0010, 3'b000, 3, 0, 2'b00);
    rd("rd10b", 32'h10, 32'hDEADABEF, 2'b00);
    rd("rdoor", 32'h1000, 32'h0, 2'b11);
    wr("wmis", 32'h13, 32'h12345678, 4'b1111, 3'b000, 0, 0, 2'b10);
    wr("woor", 32'h1000, 32'h12345678, 4'b1111, 3'b000, 0, 0, 2'b11);
    wr("wstrb0", 32'h10, 32'h12345678, 4'b0000, 3'b000, 0, 0, 2'b00);
    rd("rd10c", 32'h10, 32'hDEADABEF, 2'b00);
    rd("rdmis", 32'h16, 32'h0, 2'b10);
    wr("wlast", 32'hFFC, 32'hCAFEF00D, 4'b1111, 3'b000, 0, 0, 2'b00);
    rd("rdlast", 32'hFFC, 32'hCAFEF00D, 2'b00);
    wr("w20", 32'h20, 32'h11111111, 4'b1111, 3'b000, 0, 0, 2'b00);
    wr("wprot", 32'h20, 32'h22222222, 4'b1111, 3'b101, 0, 5, 2'b10);
    rd("rd20", 32'h20, 32'h11111111, 2'b00);
    // read sample of 0x30 lands on the same edge as a write commit to it
    wr("w30", 32'h30, 32'h1, 4'b1111, 3'b000, 0, 0, 2'b00);
    @(negedge clk);
    arvalid = 1'b1; araddress = 32'h30;
    @(negedge clk);
    arvalid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    awvalid = 1'b1; awaddress = 32'h30; awprot = 3'b000;
    wvalid = 1'b1; wdata = 32'h2; wstrb = 4'b1111;
    @(negedge clk);
    {awvalid, wvalid} = 2'b00;
    chk("coll rvalid", rvalid, 1);
    chk("coll rdata", rdata, 32'h1);
    chk("coll bvalid", bvalid, 1);
    {rready, bready} = 2'b11;
    @(negedge clk);
    {rready, bready} = 2'b00;
    chk("coll done", {rvalid, bvalid}, 2'b00);
    rd("rd30", 32'h30, 32'h2, 2'b00);
    @(negedge clk);
    arvalid = 1'b1; araddress = 32'h20;
    @(negedge clk);
    arvalid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid reset rvalid", rvalid, 0);
    chk("mid reset arready", arready, 1);
    chk("mid reset write side", {awready, wready, bvalid}, 3'b110);
    @(negedge clk);
    chk("mid reset stays idle", rvalid, 0);
    rd("rdkeep", 32'h10, 32'hDEADABEF, 2'b00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
